inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction-fetch stage of the MIPS core and the initiator side of the instruction-memory read interface. Owns the PC, drives the chip-enable and byte address into the combinational instruction ROM, and captures the returned word into the IF/ID pipeline register. Handles stall, branch redirect (one delay slot), exception entry and eret return.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- EXC_VECTOR, 32'h0000_0020, exception entry address
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hold PC and IF/ID (hazard from ID/EX)
- branch_taken  in  1  redirect request from ID (delay-slot semantics)
- branch_target  in  32  redirect address
- exc_req  in  1  take exception: fetch EXC_VECTOR, flush IF/ID
- eret  in  1  return from exception: fetch epc, flush IF/ID
- epc  in  32  return address from CP0
- inst_ce  out  1  instruction memory chip enable
- inst_addr  out  32  byte address to instruction memory (equals PC)
- inst_data  in  32  word returned combinationally by memory
- id_valid  out  1  IF/ID holds a real instruction
- id_pc  out  32  PC of id_inst
- id_inst  out  32  captured instruction
- id_adel  out  1  id_pc was misaligned (address error on fetch)

## Operation
- Next-PC priority, highest first: exc_req → EXC_VECTOR; eret → epc; stall → hold; branch_taken → branch_target; else pc+4.
- pc+4 is modulo 2^32: 32'hFFFF_FFFC wraps to 0.
- stall beats branch_taken: ID is frozen and re-presents the branch next unstalled cycle.
- Branch redirect does not flush IF/ID: the word fetched in the same cycle is the delay slot and enters ID normally.
- exc_req / eret flush: IF/ID loads id_valid=0, id_inst=32'h0, id_pc=0, id_adel=0 regardless of stall.
- Normal capture (no stall, no flush): id_pc←pc, id_valid←1, id_inst←inst_data; if pc[1:0]≠0 then id_inst←32'h0 and id_adel←1.
- Stall without flush: IF/ID and PC hold all values.
- exc_req and eret together: exc_req wins.

## Timing
- Reset (rst_n low, asynchronous): pc=RESET_PC, inst_ce=0, inst_addr=RESET_PC, id_valid=0, id_pc=0, id_inst=0, id_adel=0.
- inst_ce is a register: 0 through reset, 1 from the first rising edge after rst_n deasserts, then stays 1.
- inst_addr is pc directly (no extra register); memory answers same cycle; id_* updates on the next edge: fetch-to-ID latency 1 cycle.
- Redirect inputs sampled at edge N; inst_addr shows new target in cycle N+1.
- First valid id_inst appears two edges after reset release (edge 1: ce rises, edge 2: capture).
- Reset mid-stall or mid-redirect: everything returns to reset values immediately; no pending redirect survives.

## Structure
- Shared package cpu_defs: RESET_PC and EXC_VECTOR defaults, NOP_INST = 32'h0, instruction-word width 32.
- One sub-module pc_gen: combinational next-PC priority mux (inputs pc, stall, branch, exc, eret, targets; output next_pc). Top holds the PC, ce and IF/ID registers.

## Test plan
- Reset release, no stimulus, ROM word k = k → inst_addr 0,4,8,…; id_inst 0,1,2 on consecutive edges, id_valid=1 from 2nd edge.
- branch_taken=1, target 32'h0000_0100 while pc=0x10 → delay-slot word at 0x10 reaches ID, next id_pc=0x100.
- stall held 3 cycles with branch_taken=1 → pc and id_* frozen, no redirect; after release branch applied once.
- exc_req=1 during stall at pc=0x40 → next inst_addr=0x20, id_valid=0; eret with epc=0x44 later → inst_addr=0x44, id_valid=0 for one cycle.
- branch_target 32'h0000_0102 → id_adel=1, id_inst=0, id_pc=0x102.
- pc=32'hFFFF_FFFC sequential → inst_addr wraps to 0; rst_n pulsed mid-run → all outputs at reset values within same cycle.

Source files
------------

// File: rtl/cpu_defs.sv
// ---------------------------------------------------------------------------
// cpu_defs
// Shared definitions for the MIPS core front end.
//   INST_W          : instruction / address word width (32)
//   RESET_PC_DEF    : default first fetch address after reset
//   EXC_VECTOR_DEF  : default exception entry address
//   NOP_INST        : all-zero word used for flushed / faulted IF/ID slots
//   word_t          : 32-bit word type
//   if_id_t         : contents of the IF/ID pipeline register
//   pc_src_e        : which source the next-PC mux selected
// ---------------------------------------------------------------------------
package cpu_defs;

    localparam int INST_W = 32;

    typedef logic [INST_W-1:0] word_t;

    localparam word_t RESET_PC_DEF   = 32'h0000_0000;
    localparam word_t EXC_VECTOR_DEF = 32'h0000_0020;
    localparam word_t NOP_INST       = 32'h0000_0000;
    localparam word_t PC_STEP        = 32'd4;

    typedef struct packed {
        logic  valid;
        word_t pc;
        word_t inst;
        logic  adel;
    } if_id_t;

    // Ordered highest priority first.
    typedef enum logic [2:0] {
        SRC_EXC,
        SRC_ERET,
        SRC_HOLD,
        SRC_BRANCH,
        SRC_SEQ
    } pc_src_e;

    // A fetch address is legal only when word aligned.
    function automatic logic misaligned(input logic [1:0] addr_lsb);
        return addr_lsb != 2'b00;
    endfunction

    // The value IF/ID takes on exception entry / eret.
    function automatic if_id_t if_id_flush();
        if_id_t f;
        f.valid = 1'b0;
        f.pc    = '0;
        f.inst  = NOP_INST;
        f.adel  = 1'b0;
        return f;
    endfunction

endpackage

// File: rtl/pc_gen.sv
// ---------------------------------------------------------------------------
// pc_gen
// Combinational next-PC selection for the fetch stage.
// Priority, highest first: exception -> eret -> stall (hold) -> branch -> pc+4.
// Ports:
//   pc_i            current PC
//   stall_i         hold request from the hazard unit
//   branch_i        branch redirect request from ID
//   branch_target_i branch destination
//   exc_i           exception entry request
//   eret_i          return-from-exception request
//   epc_i           return address from CP0
//   next_pc_o       PC to load on the next clock edge
// ---------------------------------------------------------------------------
module pc_gen
    import cpu_defs::*;
#(
    parameter word_t EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic [INST_W-1:0] pc_i,
    input  logic              stall_i,
    input  logic              branch_i,
    input  logic [INST_W-1:0] branch_target_i,
    input  logic              exc_i,
    input  logic              eret_i,
    input  logic [INST_W-1:0] epc_i,
    output logic [INST_W-1:0] next_pc_o
);

    pc_src_e src;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        src = SRC_SEQ;
        if (exc_i) begin
            src = SRC_EXC;
        end else if (eret_i) begin
            src = SRC_ERET;
        end else if (stall_i) begin
            // ID is frozen, so a pending branch is re-presented later.
            src = SRC_HOLD;
        end else if (branch_i) begin
            src = SRC_BRANCH;
        end
    end

    always_comb begin
        next_pc_o = pc_i + PC_STEP;  // 32-bit add: 0xFFFF_FFFC wraps to 0
        case (src)
            SRC_EXC:    next_pc_o = EXC_VECTOR;
            SRC_ERET:   next_pc_o = epc_i;
            SRC_HOLD:   next_pc_o = pc_i;
            SRC_BRANCH: next_pc_o = branch_target_i;
            default:    next_pc_o = pc_i + PC_STEP;
        endcase
    end

endmodule

// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
// Instruction-fetch stage: owns the PC, drives the combinational instruction
// ROM and captures the returned word into the IF/ID register.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   stall           hold PC and IF/ID
//   branch_taken    redirect from ID (the word fetched alongside is the
//                   delay slot and is kept)
//   branch_target   redirect address
//   exc_req         go to EXC_VECTOR and flush IF/ID
//   eret            go to epc and flush IF/ID
//   epc             return address from CP0
//   inst_ce         instruction memory chip enable (registered)
//   inst_addr       byte address to memory (the PC itself)
//   inst_data       word returned by memory in the same cycle
//   id_valid        IF/ID holds a real instruction
//   id_pc           PC of id_inst
//   id_inst         captured instruction (0 on a misaligned fetch)
//   id_adel         id_pc was misaligned
// ---------------------------------------------------------------------------
module inst_fetch
    import cpu_defs::*;
#(
    parameter word_t RESET_PC   = RESET_PC_DEF,
    parameter word_t EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [INST_W-1:0] branch_target,
    input  logic              exc_req,
    input  logic              eret,
    input  logic [INST_W-1:0] epc,
    output logic              inst_ce,
    output logic [INST_W-1:0] inst_addr,
    input  logic [INST_W-1:0] inst_data,
    output logic              id_valid,
    output logic [INST_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst,
    output logic              id_adel
);

    word_t  pc_q, pc_d;
    logic   ce_q, ce_d;
    if_id_t if_id_q, if_id_d;
    word_t  next_pc;

    pc_gen #(
        .EXC_VECTOR(EXC_VECTOR)
    ) u_pc_gen (
        .pc_i           (pc_q),
        .stall_i        (stall),
        .branch_i       (branch_taken),
        .branch_target_i(branch_target),
        .exc_i          (exc_req),
        .eret_i         (eret),
        .epc_i          (epc),
        .next_pc_o      (next_pc)
    );

    always_comb begin
        pc_d    = pc_q;
        if_id_d = if_id_q;
        ce_d    = 1'b1;  // enable rises on the first edge after reset and stays

        // Until memory is enabled nothing has been fetched, so the PC and
        // IF/ID wait; the first capture happens on the second edge.
        if (ce_q) begin
            pc_d = next_pc;
            if (exc_req || eret) begin
                // Flush wins over stall: the frozen ID instruction is abandoned.
                if_id_d = if_id_flush();
            end else if (!stall) begin
                if_id_d.valid = 1'b1;
                if_id_d.pc    = pc_q;
                if (misaligned(pc_q[1:0])) begin
                    if_id_d.inst = NOP_INST;
                    if_id_d.adel = 1'b1;
                end else begin
                    if_id_d.inst = inst_data;
                    if_id_d.adel = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            ce_q    <= 1'b0;
            if_id_q <= if_id_flush();
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples its pre-edge value, independent of order.
            pc_q    <= pc_d;
            ce_q    <= ce_d;
            if_id_q <= if_id_d;
        end
    end

    assign inst_ce   = ce_q;
    assign inst_addr = pc_q;
    assign id_valid  = if_id_q.valid;
    assign id_pc     = if_id_q.pc;
    assign id_inst   = if_id_q.inst;
    assign id_adel   = if_id_q.adel;

endmodule

// File: tb/tb_inst_fetch.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch
// Directed bench for inst_fetch. ROM model: the word at byte address A is
// A >> 2 (word k holds k). Expected outputs are pushed to a scoreboard queue
// when stimulus is applied and popped and compared after the clock edge.
// ---------------------------------------------------------------------------
module tb_inst_fetch;

    typedef struct {
        logic        ce;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        exc_req;
    logic        eret;
    logic [31:0] epc;
    logic        inst_ce;
    logic [31:0] inst_addr;
    logic [31:0] inst_data;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_adel;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    inst_fetch dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .exc_req      (exc_req),
        .eret         (eret),
        .epc          (epc),
        .inst_ce      (inst_ce),
        .inst_addr    (inst_addr),
        .inst_data    (inst_data),
        .id_valid     (id_valid),
        .id_pc        (id_pc),
        .id_inst      (id_inst),
        .id_adel      (id_adel)
    );

    always #5 clk = ~clk;

    // Combinational ROM: word k holds k.
    assign inst_data = {2'b00, inst_addr[31:2]};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach summary (observed=timeout expected=finish)");
        $fatal(1, "watchdog expired");
    end

    task automatic push_exp(input logic ce, input logic [31:0] addr, input logic valid,
                            input logic [31:0] pc, input logic [31:0] inst, input logic adel);
        exp_t e;
        e.ce = ce; e.addr = addr; e.valid = valid; e.pc = pc; e.inst = inst; e.adel = adel;
        sb.push_back(e);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            failures++;
            $error("FAIL %s scoreboard observed=empty expected=entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            assert (inst_ce === e.ce) else begin
                failures++;
                $error("FAIL %s inst_ce observed=%b expected=%b", tag, inst_ce, e.ce);
            end
            checks++;
            assert (inst_addr === e.addr) else begin
                failures++;
                $error("FAIL %s inst_addr observed=%h expected=%h", tag, inst_addr, e.addr);
            end
            checks++;
            assert (id_valid === e.valid) else begin
                failures++;
                $error("FAIL %s id_valid observed=%b expected=%b", tag, id_valid, e.valid);
            end
            checks++;
            assert (id_pc === e.pc) else begin
                failures++;
                $error("FAIL %s id_pc observed=%h expected=%h", tag, id_pc, e.pc);
            end
            checks++;
            assert (id_inst === e.inst) else begin
                failures++;
                $error("FAIL %s id_inst observed=%h expected=%h", tag, id_inst, e.inst);
            end
            checks++;
            assert (id_adel === e.adel) else begin
                failures++;
                $error("FAIL %s id_adel observed=%b expected=%b", tag, id_adel, e.adel);
            end
        end
    endtask

    // Push expectation, advance one edge, compare #1 after it. ce expected 1.
    task automatic edge_chk(input string tag, input logic [31:0] addr, input logic valid,
                            input logic [31:0] pc, input logic [31:0] inst, input logic adel);
        push_exp(1'b1, addr, valid, pc, inst, adel);
        @(posedge clk);
        #1;
        check_out(tag);
    endtask

    task automatic clear_inputs();
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        exc_req       = 1'b0;
        eret          = 1'b0;
        epc           = 32'h0;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();

        // Reset state (a posedge at t=5 occurs while reset is held).
        #12;
        push_exp(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        check_out("reset");
        rst_n = 1'b1;

        // Sequential fetch: edge 1 raises ce, edge 2 first capture.
        edge_chk("e1_ce",   32'h0,   1'b0, 32'h0, 32'h0, 1'b0);
        edge_chk("e2_cap0", 32'h4,   1'b1, 32'h0, 32'h0, 1'b0);
        edge_chk("e3_cap1", 32'h8,   1'b1, 32'h4, 32'h1, 1'b0);
        edge_chk("e4_cap2", 32'hC,   1'b1, 32'h8, 32'h2, 1'b0);
        edge_chk("e5_cap3", 32'h10,  1'b1, 32'hC, 32'h3, 1'b0);

        // Branch at pc=0x10: delay slot (word 4) enters ID, then target.
        branch_taken = 1'b1; branch_target = 32'h100;
        edge_chk("br_slot", 32'h100, 1'b1, 32'h10, 32'h4, 1'b0);
        clear_inputs();
        edge_chk("br_tgt",  32'h104, 1'b1, 32'h100, 32'h40, 1'b0);

        // Stall beats branch for three cycles, then branch applied once.
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h200;
        edge_chk("stall1",  32'h104, 1'b1, 32'h100, 32'h40, 1'b0);
        edge_chk("stall2",  32'h104, 1'b1, 32'h100, 32'h40, 1'b0);
        edge_chk("stall3",  32'h104, 1'b1, 32'h100, 32'h40, 1'b0);
        stall = 1'b0;
        edge_chk("stall_br", 32'h200, 1'b1, 32'h104, 32'h41, 1'b0);
        clear_inputs();
        edge_chk("post_br", 32'h204, 1'b1, 32'h200, 32'h80, 1'b0);

        // Get to pc=0x40, then exception during stall.
        branch_taken = 1'b1; branch_target = 32'h40;
        edge_chk("to_40",   32'h40,  1'b1, 32'h204, 32'h81, 1'b0);
        clear_inputs();
        stall = 1'b1; exc_req = 1'b1;
        edge_chk("exc",     32'h20,  1'b0, 32'h0, 32'h0, 1'b0);
        clear_inputs();
        edge_chk("exc_v0",  32'h24,  1'b1, 32'h20, 32'h8, 1'b0);
        edge_chk("exc_v1",  32'h28,  1'b1, 32'h24, 32'h9, 1'b0);

        // eret to 0x44: one bubble, then the epc word.
        eret = 1'b1; epc = 32'h44;
        edge_chk("eret",    32'h44,  1'b0, 32'h0, 32'h0, 1'b0);
        clear_inputs();
        edge_chk("eret_v",  32'h48,  1'b1, 32'h44, 32'h11, 1'b0);

        // exc_req and eret together: exception wins.
        exc_req = 1'b1; eret = 1'b1; epc = 32'h44;
        edge_chk("exc_eret", 32'h20, 1'b0, 32'h0, 32'h0, 1'b0);
        clear_inputs();
        edge_chk("exc_eret_v", 32'h24, 1'b1, 32'h20, 32'h8, 1'b0);

        // Misaligned branch target.
        branch_taken = 1'b1; branch_target = 32'h102;
        edge_chk("to_102",  32'h102, 1'b1, 32'h24, 32'h9, 1'b0);
        clear_inputs();
        edge_chk("adel0",   32'h106, 1'b1, 32'h102, 32'h0, 1'b1);
        edge_chk("adel1",   32'h10A, 1'b1, 32'h106, 32'h0, 1'b1);

        // PC wrap at the top of the address space.
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
        edge_chk("to_top",  32'hFFFF_FFFC, 1'b1, 32'h10A, 32'h0, 1'b1);
        clear_inputs();
        edge_chk("wrap",    32'h0,   1'b1, 32'hFFFF_FFFC, 32'h3FFF_FFFF, 1'b0);
        edge_chk("wrap_nx", 32'h4,   1'b1, 32'h0, 32'h0, 1'b0);

        // Asynchronous reset mid-stall / mid-redirect.
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h300;
        #2;
        rst_n = 1'b0;
        #1;
        push_exp(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        check_out("async_rst");
        push_exp(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        check_out("rst_held");
        clear_inputs();
        rst_n = 1'b1;
        edge_chk("rr_ce",   32'h0,   1'b0, 32'h0, 32'h0, 1'b0);
        edge_chk("rr_cap0", 32'h4,   1'b1, 32'h0, 32'h0, 1'b0);
        edge_chk("rr_cap1", 32'h8,   1'b1, 32'h4, 32'h1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
